// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the FIFO write-port arbiter slice.
package Shared_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int N_REQ      = 4;
    localparam int MAX_BURST  = 4;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the arbiter, bundled as one port.
interface fifo_wr_arbiter_if
    import Shared_pkg::*;
#(
    parameter int NR = N_REQ,
    parameter int IW = (NR > 1) ? $clog2(NR) : 1
);
    logic [NR-1:0]            req;
    logic [NR-1:0]            req_last;
    logic [NR*FIFO_WIDTH-1:0] req_data;
    logic [NR-1:0]            gnt;
    logic                     fifo_rd_en;
    logic                     fifo_empty;
    logic                     fifo_wr_en;
    logic [FIFO_WIDTH-1:0]    fifo_din;
    logic [LEVEL_W-1:0]       level;
    logic [IW-1:0]            owner;
    logic                     locked;

    // Producers / FIFO model side.
    modport master (
        output req, req_last, req_data, fifo_rd_en, fifo_empty,
        input  gnt, fifo_wr_en, fifo_din, level, owner, locked
    );

    // Arbiter side.
    modport slave (
        input  req, req_last, req_data, fifo_rd_en, fifo_empty,
        output gnt, fifo_wr_en, fifo_din, level, owner, locked
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_pick #(
    parameter int NR = 4,
    parameter int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic [NR-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [NR-1:0] onehot_o,
    output logic [IW-1:0] idx_o
);

    // Scan from ptr_i+1 upward modulo NR; the first hit wins.
    always_comb begin : pick_search
        int   cand;
        logic found;
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NR; k++) begin
            cand = (int'(ptr_i) + k) % NR;
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = IW'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port, with an
// internal credit counter so the FIFO is never written while full.
module fifo_wr_arbiter
    import Shared_pkg::*;
#(
    parameter int NR = N_REQ,
    parameter int MB = MAX_BURST,
    parameter int IW = (NR > 1) ? $clog2(NR) : 1
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam logic [LEVEL_W-1:0] DEPTH_C    = LEVEL_W'(FIFO_DEPTH);
    localparam logic [LEVEL_W-1:0] BEAT_LAST  = LEVEL_W'(MB - 1);
    localparam logic [IW-1:0]      PTR_RESET  = IW'(NR - 1);

    arb_state_e            state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         owner_q;
    logic [LEVEL_W-1:0]    beat_q;
    logic [LEVEL_W-1:0]    level_q;
    logic                  locked_q;
    logic                  wr_en_q;
    logic [FIFO_WIDTH-1:0] din_q;

    logic [NR-1:0]         pick_onehot_s;
    logic [IW-1:0]         pick_idx_s;
    logic [NR-1:0]         gnt_s;
    logic [IW-1:0]         sel_idx_s;
    logic                  space_s;
    logic                  pop_s;
    logic                  accept_s;
    logic                  last_s;
    logic [LEVEL_W-1:0]    level_d;

    rr_pick #(.NR(NR), .IW(IW)) u_pick (
        .req_i    (bus.req),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s)
    );

    // Grant decode from registered state; full FIFO or reset blocks everyone.
    always_comb begin
        gnt_s     = '0;
        sel_idx_s = (state_q == IDLE) ? pick_idx_s : owner_q;
        space_s   = (level_q < DEPTH_C);
        if (rst || !space_s) begin
            gnt_s = '0;
        end else if (state_q == IDLE) begin
            gnt_s = pick_onehot_s;
        end else if (bus.req[owner_q]) begin
            gnt_s[owner_q] = 1'b1;
        end else begin
            gnt_s = '0;
        end
        accept_s = |(gnt_s & bus.req);
        pop_s    = bus.fifo_rd_en && !bus.fifo_empty;
        last_s   = bus.req_last[sel_idx_s];
        level_d  = level_q + {{(LEVEL_W-1){1'b0}}, accept_s}
                           - {{(LEVEL_W-1){1'b0}}, pop_s};
    end

    // FSM, credit counter and the registered FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= PTR_RESET;
            owner_q  <= '0;
            beat_q   <= '0;
            level_q  <= '0;
            locked_q <= 1'b0;
            wr_en_q  <= 1'b0;
            din_q    <= '0;
        end else begin
            level_q <= level_d;
            wr_en_q <= accept_s;
            if (accept_s) begin
                din_q <= bus.req_data[int'(sel_idx_s)*FIFO_WIDTH +: FIFO_WIDTH];
            end
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        if (last_s || (MB == 1)) begin
                            rr_ptr_q <= sel_idx_s;
                        end else begin
                            state_q  <= BURST;
                            owner_q  <= sel_idx_s;
                            beat_q   <= LEVEL_W'(1);
                            locked_q <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (accept_s) begin
                        if (last_s || (beat_q == BEAT_LAST)) begin
                            state_q  <= IDLE;
                            rr_ptr_q <= owner_q;
                            locked_q <= 1'b0;
                            beat_q   <= '0;
                        end else begin
                            beat_q <= beat_q + LEVEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    locked_q <= 1'b0;
                    beat_q   <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_s;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_din   = din_q;
    assign bus.level      = level_q;
    assign bus.owner      = owner_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
    import Shared_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NR(4)) bif ();

    fifo_wr_arbiter #(.NR(4), .MB(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       rd;
        logic       empty;
        logic [3:0] gnt;
        logic       locked;
        logic [1:0] owner;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    logic [15:0] din_m = 16'h0000;
    logic        wr_m  = 1'b0;
    int          lvl_m = 0;

    vec_t vecs [29];

    function automatic logic [15:0] word_of(int i, int n);
        return {4'(i), 4'h0, 8'(n)};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, step_no, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        int gidx;
        @(negedge clk);
        rst            = v.rst;
        bif.req        = v.req;
        bif.req_last   = v.last;
        bif.fifo_rd_en = v.rd;
        bif.fifo_empty = v.empty;
        for (int i = 0; i < 4; i++) bif.req_data[i*16 +: 16] = word_of(i, step_no);
        #1;
        chk("gnt", int'(bif.gnt), int'(v.gnt));
        gidx = 0;
        for (int i = 0; i < 4; i++) if (v.gnt[i]) gidx = i;
        @(posedge clk);
        #1;
        if (v.rst) begin
            din_m = 16'h0000;
            wr_m  = 1'b0;
            lvl_m = 0;
        end else begin
            wr_m = (v.gnt != 4'b0000);
            if (wr_m) din_m = word_of(gidx, step_no);
            lvl_m = lvl_m + (wr_m ? 1 : 0) - ((v.rd && !v.empty) ? 1 : 0);
        end
        chk("fifo_wr_en", int'(bif.fifo_wr_en), int'(wr_m));
        chk("fifo_din", int'(bif.fifo_din), int'(din_m));
        chk("level", int'(bif.level), lvl_m);
        chk("locked", int'(bif.locked), int'(v.locked));
        if (v.locked) chk("owner", int'(bif.owner), int'(v.owner));
        step_no++;
    endtask

    initial begin
        bif.req        = 4'b0000;
        bif.req_last   = 4'b0000;
        bif.req_data   = '0;
        bif.fifo_rd_en = 1'b0;
        bif.fifo_empty = 1'b1;

        // Reset then idle.
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        // Round-robin fairness, single-word bursts, pop every cycle.
        vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
        vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd0};
        vecs[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
        vecs[8]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
        vecs[9]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0};
        vecs[10] = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 4'b1000, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        // Burst lock by requester 0; requester 1 blocked even when owner idles.
        vecs[12] = '{1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 4'h3, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[14] = '{1'b0, 4'h2, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0};
        vecs[15] = '{1'b0, 4'h3, 4'h1, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0};
        vecs[16] = '{1'b0, 4'h3, 4'h2, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0};
        vecs[17] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[18] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[19] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        vecs[20] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};
        // MAX_BURST cut on requester 2, then re-won for two more words.
        vecs[21] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[22] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[23] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[24] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b0, 2'd0};
        vecs[25] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[26] = '{1'b0, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2};
        // Reset mid-burst (beat count 2), then a pop against an empty FIFO.
        vecs[27] = '{1'b1, 4'h4, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[28] = '{1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};

        for (int n = 0; n < 29; n++) step(vecs[n]);
        chk("empty_pop_level", int'(bif.level), 0);

        // Full stall: eight words fill the FIFO, the ninth is held off.
        for (int k = 0; k < 8; k++)
            step('{1'b0, 4'h1, 4'h1, 1'b0, 1'b1, 4'b0001, 1'b0, 2'd0});
        chk("full_level", int'(bif.level), 8);
        step('{1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0});
        chk("full_level_held", int'(bif.level), 8);
        // Pop while full: still no same-cycle grant, space appears next cycle.
        step('{1'b0, 4'h1, 4'h1, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0});
        chk("after_pop_level", int'(bif.level), 7);
        step('{1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0});
        chk("refill_level", int'(bif.level), 8);
        step('{1'b0, 4'h1, 4'h1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
